// File: rtl/regfile_mp_if.sv
// Register-file port bundle: read ports, ALU/load-return write ports and load scoreboard controls.
// The issue/execute side uses the master modport; the register file uses the slave modport.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] Read_addr;
    logic [NUM_RD*DATA_W-1:0] Read_data;
    logic [NUM_RD-1:0]        Read_busy;
    logic                     W0_en;
    logic [ADDR_W-1:0]        W0_addr;
    logic [DATA_W-1:0]        W0_data;
    logic                     W1_en;
    logic [ADDR_W-1:0]        W1_addr;
    logic [DATA_W-1:0]        W1_data;
    logic                     Busy_set;
    logic [ADDR_W-1:0]        Busy_addr;
    logic                     Busy_any;

    modport master (
        output Read_addr, W0_en, W0_addr, W0_data, W1_en, W1_addr, W1_data, Busy_set, Busy_addr,
        input  Read_data, Read_busy, Busy_any
    );

    modport slave (
        input  Read_addr, W0_en, W0_addr, W0_data, W1_en, W1_addr, W1_data, Busy_set, Busy_addr,
        output Read_data, Read_busy, Busy_any
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with a per-register load scoreboard for the two-stage core.
// W1 (load return) beats W0 (ALU) on a same-address conflict; x0 is hardwired to zero and never busy.
module regfile_mp #(
    parameter int               DATA_W   = 32,
    parameter int               ADDR_W   = 5,
    parameter int               NUM_RD   = 2,
    parameter int               SP_IDX   = 2,
    parameter logic [DATA_W-1:0] SP_RESET = 32'd1024,
    parameter bit               BYPASS   = 1'b1
) (
    input logic        Clock,
    input logic        Reset_n,
    regfile_mp_if.slave rf
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    logic [ADDR_W-1:0] ra_s [NUM_RD];
    logic              w0_nz_s;
    logic              w1_nz_s;
    logic              bset_nz_s;

    assign w0_nz_s   = rf.W0_en    && (rf.W0_addr   != '0);
    assign w1_nz_s   = rf.W1_en    && (rf.W1_addr   != '0);
    assign bset_nz_s = rf.Busy_set && (rf.Busy_addr != '0);

    // Register array and busy bits; the W1 assignment follows W0 so it wins a same-address conflict.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= (i == SP_IDX) ? SP_RESET : {DATA_W{1'b0}};
            end
            busy_r <= '0;
        end else begin
            if (w0_nz_s) begin
                regs_r[rf.W0_addr] <= rf.W0_data;
            end
            if (w1_nz_s) begin
                regs_r[rf.W1_addr] <= rf.W1_data;
                busy_r[rf.W1_addr] <= 1'b0;
            end
            // Set after clear: a new load to the register just returned keeps it pending.
            if (bset_nz_s) begin
                busy_r[rf.Busy_addr] <= 1'b1;
            end
        end
    end

    // Unpack the per-port read indices.
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            ra_s[k] = rf.Read_addr[k*ADDR_W +: ADDR_W];
        end
    end

    // Read ports with optional same-cycle forwarding; load return takes precedence over ALU.
    always_comb begin
        rf.Read_data = '0;
        rf.Read_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (ra_s[k] == '0) begin
                rf.Read_data[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                rf.Read_busy[k]                  = 1'b0;
            end else if (BYPASS && rf.W1_en && (rf.W1_addr == ra_s[k])) begin
                rf.Read_data[k*DATA_W +: DATA_W] = rf.W1_data;
                rf.Read_busy[k]                  = rf.Busy_set && (rf.Busy_addr == ra_s[k]);
            end else if (BYPASS && rf.W0_en && (rf.W0_addr == ra_s[k])) begin
                rf.Read_data[k*DATA_W +: DATA_W] = rf.W0_data;
                rf.Read_busy[k]                  = busy_r[ra_s[k]];
            end else begin
                rf.Read_data[k*DATA_W +: DATA_W] = regs_r[ra_s[k]];
                rf.Read_busy[k]                  = busy_r[ra_s[k]];
            end
        end
    end

    assign rf.Busy_any = |busy_r;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a forwarding instance and a non-forwarding instance share stimulus;
// each cycle's expected outputs are queued when driven and checked just before the committing edge.
module tb_regfile_mp;
    typedef struct {
        logic        rst_n;
        logic        w0_en;
        logic [4:0]  w0_addr;
        logic [31:0] w0_data;
        logic        w1_en;
        logic [4:0]  w1_addr;
        logic [31:0] w1_data;
        logic        bset;
        logic [4:0]  baddr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] nd1;
        logic        b0;
        logic        b1;
        logic        any;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] nd1;
        logic        b0;
        logic        b1;
        logic        any;
    } exp_t;

    logic   clock_s;
    logic   reset_n_s;
    int     n_compared;
    int     n_mismatched;
    exp_t   exp_q[$];
    vec_t   vecs[21];
    vec_t   seq[5];

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bif ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) nif ();

    assign nif.Read_addr = bif.Read_addr;
    assign nif.W0_en     = bif.W0_en;
    assign nif.W0_addr   = bif.W0_addr;
    assign nif.W0_data   = bif.W0_data;
    assign nif.W1_en     = bif.W1_en;
    assign nif.W1_addr   = bif.W1_addr;
    assign nif.W1_data   = bif.W1_data;
    assign nif.Busy_set  = bif.Busy_set;
    assign nif.Busy_addr = bif.Busy_addr;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .SP_IDX(2), .SP_RESET(32'd1024), .BYPASS(1'b1))
        dut_byp (.Clock(clock_s), .Reset_n(reset_n_s), .rf(bif.slave));

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .SP_IDX(2), .SP_RESET(32'd1024), .BYPASS(1'b0))
        dut_nobyp (.Clock(clock_s), .Reset_n(reset_n_s), .rf(nif.slave));

    initial begin
        clock_s = 1'b0;
        forever #5 clock_s = ~clock_s;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clock_s);
        reset_n_s     = v.rst_n;
        bif.W0_en     = v.w0_en;
        bif.W0_addr   = v.w0_addr;
        bif.W0_data   = v.w0_data;
        bif.W1_en     = v.w1_en;
        bif.W1_addr   = v.w1_addr;
        bif.W1_data   = v.w1_data;
        bif.Busy_set  = v.bset;
        bif.Busy_addr = v.baddr;
        bif.Read_addr = {v.ra1, v.ra0};
        e.name = name;
        e.d0   = v.d0;
        e.d1   = v.d1;
        e.nd1  = v.nd1;
        e.b0   = v.b0;
        e.b1   = v.b1;
        e.any  = v.any;
        exp_q.push_back(e);
        #2;
        got = exp_q.pop_front();
        check({got.name, ".d0"},   bif.Read_data[31:0],         got.d0);
        check({got.name, ".d1"},   bif.Read_data[63:32],        got.d1);
        check({got.name, ".nd1"},  nif.Read_data[63:32],        got.nd1);
        check({got.name, ".b0"},   {31'd0, bif.Read_busy[0]},   {31'd0, got.b0});
        check({got.name, ".b1"},   {31'd0, bif.Read_busy[1]},   {31'd0, got.b1});
        check({got.name, ".any"},  {31'd0, bif.Busy_any},       {31'd0, got.any});
    endtask

    initial begin
        n_compared    = 0;
        n_mismatched  = 0;
        reset_n_s     = 1'b0;
        bif.W0_en     = 1'b0;
        bif.W0_addr   = 5'd0;
        bif.W0_data   = 32'd0;
        bif.W1_en     = 1'b0;
        bif.W1_addr   = 5'd0;
        bif.W1_data   = 32'd0;
        bif.Busy_set  = 1'b0;
        bif.Busy_addr = 5'd0;
        bif.Read_addr = 10'd0;

        //            rst   w0e   w0a    w0d            w1e   w1a    w1d        bs    ba     ra0    ra1    d0             d1          nd1         b0    b1    any
        vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd2,  5'd5,  32'd1024,      32'h0,      32'h0,      1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF,  1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd5,  5'd2,  32'hDEADBEEF,  32'd1024,   32'd1024,   1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 5'd0,  32'h7,         1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF,  32'h0,      32'h0,      1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd31, 32'h0,         32'h0,      32'h0,      1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 5'd9,  32'h55,        1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd9,  5'd9,  32'h55,        32'h55,     32'h0,      1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd9,  5'd9,  32'h55,        32'h55,     32'h55,     1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 5'd3,  32'h11,        1'b1, 5'd3,  32'h22,    1'b0, 5'd0,  5'd3,  5'd3,  32'h22,        32'h22,     32'h0,      1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd3,  5'd1,  32'h22,        32'h0,      32'h0,      1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,     1'b1, 5'd7,  5'd7,  5'd7,  32'h0,         32'h0,      32'h0,      1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd7,  5'd7,  32'h0,         32'h0,      32'h0,      1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  32'h99,    1'b1, 5'd7,  5'd7,  5'd7,  32'h99,        32'h99,     32'h0,      1'b1, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd7,  5'd7,  32'h99,        32'h99,     32'h99,     1'b1, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  32'hA0,    1'b0, 5'd0,  5'd7,  5'd6,  32'hA0,        32'h0,      32'h0,      1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd7,  5'd7,  32'hA0,        32'hA0,     32'hA0,     1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,     1'b1, 5'd4,  5'd4,  5'd2,  32'h0,         32'd1024,   32'd1024,   1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 5'd4,  32'h33,        1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd4,  5'd4,  32'h33,        32'h33,     32'h0,      1'b1, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 5'd4,  32'h10,    1'b0, 5'd0,  5'd4,  5'd4,  32'h10,        32'h10,     32'h0,      1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd4,  5'd5,  32'h10,        32'h0,      32'h0,      1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'h77,    1'b1, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,      32'h0,      1'b0, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 5'd2,  32'h44,        1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd2,  32'h0,         32'h44,     32'd1024,   1'b0, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd2,  5'd2,  32'h44,        32'h44,     32'h44,     1'b0, 1'b0, 1'b0};

        // Two overlapping loads; an ALU write to a pending register leaves it pending.
        seq[0]   = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,     1'b1, 5'd10, 5'd10, 5'd11, 32'h0,         32'h0,      32'h0,      1'b0, 1'b0, 1'b0};
        seq[1]   = '{1'b1, 1'b1, 5'd11, 32'h5,         1'b1, 5'd10, 32'h1,     1'b1, 5'd11, 5'd10, 5'd11, 32'h1,         32'h5,      32'h0,      1'b0, 1'b0, 1'b1};
        seq[2]   = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd10, 5'd11, 32'h1,         32'h5,      32'h5,      1'b0, 1'b1, 1'b1};
        seq[3]   = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 5'd11, 32'h2,     1'b0, 5'd0,  5'd11, 5'd10, 32'h2,         32'h1,      32'h1,      1'b0, 1'b0, 1'b1};
        seq[4]   = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd10, 5'd11, 32'h1,         32'h2,      32'h2,      1'b0, 1'b0, 1'b0};

        @(posedge clock_s);
        for (int i = 0; i < 21; i++) begin
            apply($sformatf("row%0d", i), vecs[i]);
        end
        for (int i = 0; i < 5; i++) begin
            apply($sformatf("seq%0d", i), seq[i]);
        end
        @(negedge clock_s);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
